// File: rtl/change_dispenser.sv
// change_dispenser: queues sale strobes, drives the brew actuator, then pays change through a coin hopper handshake.
// Define CHANGE_100_EN to enable 100-coin payout; otherwise coin100 stays 0 and all change goes out as 50 coins.
module change_dispenser #(
    parameter int BREW_CYCLES = 8,
    parameter int QUEUE_DEPTH = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coffee,
    input  logic [1:0] remain,
    input  logic       coin_ack,
    output logic       brew,
    output logic       coin50,
    output logic       coin100,
    output logic       busy,
    output logic       overflow,
    output logic       fault
);

`ifdef CHANGE_100_EN
    localparam logic EN_100 = 1'b1;
`else
    localparam logic EN_100 = 1'b0;
`endif

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_MAX = (BREW_CYCLES > ACK_TIMEOUT) ? BREW_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BREW_LAST = CNT_W'(BREW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   Q_ZERO    = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   Q_ONE     = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   Q_FULL    = (PTR_W + 1)'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BREW  = 3'd1,
        S_PAY   = 3'd2,
        S_GAP   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state_q;
    logic [1:0]       owed_q;
    logic [CNT_W-1:0] cnt_q;
    logic             brew_q;
    logic             coin50_q;
    logic             coin100_q;
    logic             busy_q;
    logic             overflow_q;
    logic             fault_q;

    logic [1:0]       mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             go_idle_s;
    logic             sel_100_s;

    // Queue storage; occupancy is tracked by the pointers, so entries need no reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= remain;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= Q_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Push/pop arbitration and the next-state terms that feed the registered busy flag.
    always_comb begin
        full_s = (count_q == Q_FULL);
        pop_s  = (state_q == S_IDLE) && (count_q != Q_ZERO);
        push_s = coffee && (!full_s || pop_s);
        if (push_s && !pop_s) begin
            count_d = count_q + Q_ONE;
        end else if (!push_s && pop_s) begin
            count_d = count_q - Q_ONE;
        end else begin
            count_d = count_q;
        end
        go_idle_s = ((state_q == S_IDLE) && !pop_s) ||
                    ((state_q == S_BREW) && (cnt_q == CNT_ZERO) && (owed_q == 2'd0)) ||
                    ((state_q == S_GAP) && (owed_q == 2'd0));
        sel_100_s = EN_100 & owed_q[1];
    end

    // Sale sequencer with registered actuator, status and sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owed_q     <= 2'd0;
            cnt_q      <= CNT_ZERO;
            brew_q     <= 1'b0;
            coin50_q   <= 1'b0;
            coin100_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            busy_q <= !go_idle_s || (count_d != Q_ZERO);
            if (coffee && !push_s) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        state_q <= S_BREW;
                        owed_q  <= mem_q[rd_ptr_q];
                        cnt_q   <= BREW_LAST;
                        brew_q  <= 1'b1;
                    end
                end
                S_BREW: begin
                    if (cnt_q == CNT_ZERO) begin
                        brew_q <= 1'b0;
                        if (owed_q == 2'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_PAY;
                            coin100_q <= sel_100_s;
                            coin50_q  <= !sel_100_s;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_PAY: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (coin_ack) begin
                        owed_q    <= owed_q - (coin100_q ? 2'd2 : 2'd1);
                        coin50_q  <= 1'b0;
                        coin100_q <= 1'b0;
                        state_q   <= S_GAP;
                    end else if (cnt_q == ACK_LAST) begin
                        coin50_q  <= 1'b0;
                        coin100_q <= 1'b0;
                        fault_q   <= 1'b1;
                        state_q   <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (owed_q != 2'd0) begin
                        state_q   <= S_PAY;
                        cnt_q     <= CNT_ZERO;
                        coin100_q <= sel_100_s;
                        coin50_q  <= !sel_100_s;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    fault_q   <= 1'b1;
                    brew_q    <= 1'b0;
                    coin50_q  <= 1'b0;
                    coin100_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    brew_q    <= 1'b0;
                    coin50_q  <= 1'b0;
                    coin100_q <= 1'b0;
                end
            endcase
        end
    end

    assign brew     = brew_q;
    assign coin50   = coin50_q;
    assign coin100  = coin100_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table of sales plus hand-written corner sequences.
module tb_change_dispenser;

    localparam int BREW_CYCLES = 8;
    localparam int QUEUE_DEPTH = 4;
    localparam int ACK_TIMEOUT = 16;

`ifdef CHANGE_100_EN
    localparam int C2 = 1;
    localparam int C3 = 2;
`else
    localparam int C2 = 2;
    localparam int C3 = 3;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       coffee;
    logic [1:0] remain;
    logic       coin_ack;
    logic       brew;
    logic       coin50;
    logic       coin100;
    logic       busy;
    logic       overflow;
    logic       fault;

    change_dispenser #(
        .BREW_CYCLES(BREW_CYCLES),
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .coffee(coffee),
        .remain(remain),
        .coin_ack(coin_ack),
        .brew(brew),
        .coin50(coin50),
        .coin100(coin100),
        .busy(busy),
        .overflow(overflow),
        .fault(fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] remain;
        int         delay;
        int         exp_coins;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   sb[$];
    int   ack_mode;
    int   ack_delay;
    int   req_age;
    int   brew_len;
    int   coin_rises;
    logic prev_req;
    logic prev_brew;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample after the edge, score coin requests, then drive the hopper ack.
    task automatic tick();
        logic req;
        int   e;
        @(posedge clock);
        #1;
        req = coin50 || coin100;
        if (req && !prev_req) begin
            coin_rises++;
            chk("coin_onehot", int'(coin50 & coin100), 0);
            if (sb.size() == 0) begin
                chk("unexpected_coin", coin100 ? 100 : 50, 0);
            end else begin
                e = sb.pop_front();
                chk("coin_type", coin100 ? 100 : 50, e);
            end
        end
        if (prev_brew && !brew) begin
            chk("brew_len", brew_len, BREW_CYCLES);
        end
        brew_len  = brew ? brew_len + 1 : 0;
        req_age   = req ? req_age + 1 : 0;
        prev_req  = req;
        prev_brew = brew;
        case (ack_mode)
            1:       coin_ack = req && (req_age == ack_delay);
            2:       coin_ack = 1'b1;
            default: coin_ack = 1'b0;
        endcase
    endtask

    task automatic push_expected(input logic [1:0] r);
`ifdef CHANGE_100_EN
        if (r[1]) sb.push_back(100);
        if (r[0]) sb.push_back(50);
`else
        for (int i = 0; i < int'(r); i++) sb.push_back(50);
`endif
    endtask

    task automatic sale(input logic [1:0] r, input bit accept);
        if (accept) push_expected(r);
        coffee = 1'b1;
        remain = r;
        tick();
        coffee = 1'b0;
        remain = 2'd0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        coffee   = 1'b0;
        remain   = 2'd0;
        ack_mode = 0;
        coin_ack = 1'b0;
        tick();
        tick();
        chk("reset_outputs", int'({brew, coin50, coin100, busy, overflow, fault}), 0);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while ((busy || brew || coin50 || coin100) && n < maxc) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic wait_req(input int maxc, input string name);
        int n = 0;
        while (!(coin50 || coin100) && n < maxc) begin
            tick();
            n++;
        end
        chk({name, "_req_seen"}, int'(coin50 || coin100), 1);
    endtask

    vec_t       vecs [5];
    logic [1:0] ovr_r [5];
    int         cnt;
    int         rises0;

    initial begin
        reset = 1'b1; coffee = 1'b0; remain = 2'd0; coin_ack = 1'b0;
        ack_mode = 0; ack_delay = 2; req_age = 0; brew_len = 0; coin_rises = 0;
        prev_req = 1'b0; prev_brew = 1'b0;

        vecs[0] = '{2'd0, 1, 0};
        vecs[1] = '{2'd1, 2, 1};
        vecs[2] = '{2'd2, 3, C2};
        vecs[3] = '{2'd3, 2, C3};
        vecs[4] = '{2'd3, ACK_TIMEOUT, C3};
        ovr_r[0] = 2'd1; ovr_r[1] = 2'd2; ovr_r[2] = 2'd3; ovr_r[3] = 2'd1; ovr_r[4] = 2'd2;

        // Plain sale with no change: exact brew window and busy release.
        do_reset();
        repeat (3) tick();
        sale(2'd0, 1'b1);
        chk("t1_brew_off_t1", int'(brew), 0);
        chk("t1_busy_t1", int'(busy), 1);
        cnt = 0;
        for (int i = 0; i < BREW_CYCLES; i++) begin
            tick();
            if (brew) cnt++;
        end
        chk("t1_brew_cycles", cnt, BREW_CYCLES);
        tick();
        chk("t1_after_brew", int'({brew, coin50, coin100, busy}), 0);

        // Vector table: each sale paid with a given hopper latency.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            ack_mode  = 1;
            ack_delay = vecs[v].delay;
            rises0    = coin_rises;
            sale(vecs[v].remain, 1'b1);
            wait_idle(300, "vec");
            chk("vec_coins", coin_rises - rises0, vecs[v].exp_coins);
            chk("vec_sb_empty", sb.size(), 0);
            chk("vec_no_fault", int'(fault), 0);
        end

        // Ack pulsed in IDLE and during BREW is ignored.
        do_reset();
        ack_mode = 2;
        repeat (3) tick();
        chk("ack_idle_ignored", int'({busy, brew, coin50, coin100}), 0);
        rises0 = coin_rises;
        sale(2'd3, 1'b1);
        repeat (BREW_CYCLES) tick();
        ack_mode  = 1;
        ack_delay = 2;
        wait_idle(300, "ackbrew");
        chk("ackbrew_coins", coin_rises - rises0, C3);
        chk("ackbrew_sb_empty", sb.size(), 0);

        // Overflow: five back-to-back strobes while brewing.
        do_reset();
        ack_mode  = 1;
        ack_delay = 2;
        sale(2'd0, 1'b1);
        tick();
        chk("ovf_brewing", int'(brew), 1);
        for (int i = 0; i < 5; i++) begin
            sale(ovr_r[i], i < QUEUE_DEPTH);
            if (i == 3) chk("ovf_not_yet", int'(overflow), 0);
            if (i == 4) chk("ovf_set", int'(overflow), 1);
        end
        wait_idle(600, "ovf");
        chk("ovf_sb_empty", sb.size(), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Hopper timeout.
        do_reset();
        sale(2'd1, 1'b1);
        wait_req(40, "tmo");
        cnt = 0;
        for (int k = 1; k <= ACK_TIMEOUT; k++) begin
            tick();
            if (k < ACK_TIMEOUT && coin50 && !fault) cnt++;
        end
        chk("tmo_hold", cnt, ACK_TIMEOUT - 1);
        chk("tmo_fault", int'(fault), 1);
        chk("tmo_outputs_off", int'({brew, coin50, coin100}), 0);
        for (int i = 0; i < 5; i++) sale(2'd1, 1'b0);
        repeat (3) tick();
        chk("tmo_overflow", int'(overflow), 1);
        chk("tmo_still_halted", int'({fault, busy, brew, coin50, coin100}), 5'b11000);

        // Reset during payment with 100 still owed.
        do_reset();
        sale(2'd2, 1'b1);
        wait_req(40, "rst");
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rst_outputs", int'({brew, coin50, coin100, busy, overflow, fault}), 0);
        reset = 1'b0;
        sb.delete();
        ack_mode  = 1;
        ack_delay = 2;
        rises0    = coin_rises;
        repeat (20) tick();
        chk("rst_no_coins", coin_rises - rises0, 0);
        chk("rst_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the coffee vending FSM. Accepts each one-cycle sale strobe (`coffee`) together with its change code (`remain`, in units of 50) and queues it. For each sale it drives the brew actuator for a fixed time, then pays the change out coin by coin through a request/acknowledge handshake with the coin hopper. Stuck-hopper timeouts are detected.

## Interface

- `BREW_CYCLES`, 8: cycles `brew` is held high per sale (≥1).
- `QUEUE_DEPTH`, 4: pending-sale queue entries (power of two, ≥2).
- `ACK_TIMEOUT`, 16: maximum cycles a coin request may wait for `coin_ack` before fault (≥2).
- `clock`  in  1  rising-edge clock shared with the vending FSM.
- `reset`  in  1  synchronous, active-high reset.
- `coffee`  in  1  one-cycle sale strobe from vending FSM.
- `remain`  in  2  change owed with the strobe: 00=0, 01=50, 10=100, 11=150; ignored when `coffee`=0.
- `coin_ack`  in  1  hopper acknowledge; one coin released when sampled high during a request.
- `brew`  out  1  brew actuator enable.
- `coin50`  out  1  request one 50 coin.
- `coin100`  out  1  request one 100 coin (only with `CHANGE_100_EN`).
- `busy`  out  1  high whenever FSM is not IDLE or queue is non-empty.
- `overflow`  out  1  sticky: a sale arrived while queue full and was dropped.
- `fault`  out  1  sticky: hopper timeout; block halted.

## Operation

- Every output resets to 0 on `reset`. Queue empties, FSM → IDLE, counters → 0.
- Push: `coffee`=1 writes `remain` into the queue at that edge.
  - Queue full with no pop in the same cycle → entry dropped, `overflow`←1.
  - Full with a simultaneous pop → push accepted.
- FSM states: IDLE, BREW, PAY, GAP, FAULT.
- IDLE: queue non-empty → pop head into `owed` (2-bit) and brew counter, → BREW.
- BREW: `brew`=1 for exactly BREW_CYCLES cycles. Then `owed`=0 → IDLE, else → PAY.
- PAY: assert exactly one coin request, held steady until `coin_ack` is sampled high.
  - Coin selection with `CHANGE_100_EN` defined: `coin100` if `owed`≥2, else `coin50`.
  - Coin selection without it: always `coin50`.
  - On ack, `owed` decrements by 2 (100) or 1 (50) → GAP.
  - If ACK_TIMEOUT cycles elapse in PAY without ack → FAULT.
- GAP: one cycle, all coin requests low, `coin_ack` ignored. Then `owed`≠0 → PAY (timeout counter cleared), else → IDLE.
- FAULT: `fault`=1, `brew`/`coin50`/`coin100`=0. Pushes continue until full (overflow still flagged). Exit only via `reset`.
- `coin_ack` outside PAY has no effect.
- `reset` mid-brew or mid-payment: outputs drop to 0 on the next edge; owed change and queued sales are discarded.

## Timing

- Sale strobe at cycle t (FSM idle, queue empty): entry visible at t+1, FSM leaves IDLE at edge t+1, `brew`=1 during cycles t+2 … t+1+BREW_CYCLES.
- First coin request is asserted in the cycle after the last `brew` cycle.
- Ack sampled at edge e drops the request in cycle e+1 (GAP). The next request, if any, starts at e+2. Minimum two cycles per coin.
- Back-to-back sales: the next sale's BREW starts the cycle after IDLE, so IDLE lasts exactly 1 cycle between sales.
- `busy` is registered and reflects the state/queue after each edge.
- Timeout: request asserted for cycles p … p+ACK_TIMEOUT−1 with no ack → FAULT from cycle p+ACK_TIMEOUT.

## Configuration

- `CHANGE_100_EN` defined: `coin100` output is active.
  - 100 change = one 100 coin.
  - 150 change = 100 coin then 50 coin.
- Not defined: `coin100` is tied to 0. All change is paid in 50 coins (150 = three 50 coins). Port list is unchanged.

## Test plan

- Reset, then `coffee`=1 `remain`=00 at cycle 5 → `brew` high cycles 7–14, no coin requests, `busy` low from cycle 15.
- `coffee` with `remain`=11, ack returned 1 cycle after each request:
  - with `CHANGE_100_EN`: `coin100` then `coin50`, each separated by a 1-cycle GAP.
  - without it: three `coin50` pulses.
- Five strobes in consecutive cycles with QUEUE_DEPTH=4 while FSM busy → 4 sales served in order, `overflow`=1 after the 5th.
- Hold `coin_ack`=0 during a 50 request → `fault`=1 exactly 16 cycles after the request rises, all actuator outputs 0 thereafter.
- Assert `reset` mid-PAY with `owed`=2 → all outputs 0 next cycle, no further coins, `busy`=0.
- `coin_ack` pulsed during BREW and IDLE → ignored, no `owed` change.
